// File: rtl/out_tx_scheduler.sv
// Round-robin scheduler that shares one byte-wide transmit link among N_CH channel buffers.
// Each granted word is sent as a header byte plus DATA_BIT/8 payload bytes, MSB first.
module out_tx_scheduler #(
    parameter int         N_CH     = 4,
    parameter int         CH_BITS  = 2,
    parameter int         DATA_BIT = 32,
    parameter int         SETTLE   = 2,
    parameter logic [3:0] HDR_TAG  = 4'hA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_go,
    input  logic [N_CH*DATA_BIT-1:0] ch_data,
    output logic [N_CH-1:0]          ch_done,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [CH_BITS-1:0]       cur_ch,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);

    localparam int N_BYTES = DATA_BIT / 8;
    localparam int IDX_W   = $clog2(N_BYTES + 1);
    localparam int PTR_W   = CH_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LATCH,
        S_HDR,
        S_PAY,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           settle_cnt, settle_nxt;
    logic [CH_BITS-1:0]   cur_nxt;
    logic [CH_BITS-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]     byte_idx, idx_nxt;
    logic [DATA_BIT-1:0]  word, word_nxt;
    logic [15:0]          cnt_nxt;
    logic                 grant_found;
    logic [CH_BITS-1:0]   grant_ch;
    logic [PTR_W-1:0]     cand;

    function automatic logic [7:0] hdr_byte(input logic [CH_BITS-1:0] ch);
        logic [2:0] ch3;
        ch3 = 3'(ch);
        return {HDR_TAG, 1'b0, ch3};
    endfunction

    function automatic logic [7:0] pay_byte(input logic [DATA_BIT-1:0] w,
                                            input logic [IDX_W-1:0]    idx);
        logic [DATA_BIT-1:0] sh;
        sh = w << {idx, 3'b000};
        return sh[DATA_BIT-1 -: 8];
    endfunction

    // Arbitration: first requester at or after rr_ptr, wrapping modulo N_CH
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, rr_ptr} + PTR_W'(i);
            if (cand >= PTR_W'(N_CH)) begin
                cand = cand - PTR_W'(N_CH);
            end
            if (!grant_found && ch_go[cand[CH_BITS-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = cand[CH_BITS-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        cur_nxt    = cur_ch;
        rr_nxt     = rr_ptr;
        idx_nxt    = byte_idx;
        word_nxt   = word;
        cnt_nxt    = frame_cnt;
        ch_done    = '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    cur_nxt    = grant_ch;
                    settle_nxt = '0;
                    state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // A withdrawn request abandons the grant without touching rr_ptr
                if (!ch_go[cur_ch]) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == 4'(SETTLE - 1)) begin
                    state_nxt = S_LATCH;
                end else begin
                    settle_nxt = settle_cnt + 4'd1;
                end
            end
            S_LATCH: begin
                word_nxt        = ch_data[int'(cur_ch)*DATA_BIT +: DATA_BIT];
                ch_done[cur_ch] = 1'b1;
                state_nxt       = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(cur_ch);
                if (tx_ready) begin
                    idx_nxt   = '0;
                    state_nxt = S_PAY;
                end
            end
            S_PAY: begin
                tx_valid = 1'b1;
                tx_data  = pay_byte(word, byte_idx);
                if (tx_ready) begin
                    if (byte_idx == IDX_W'(N_BYTES - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt = byte_idx + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                cnt_nxt   = frame_cnt + 16'd1;
                rr_nxt    = (cur_ch == CH_BITS'(N_CH - 1)) ? '0 : cur_ch + CH_BITS'(1);
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            cur_ch     <= '0;
            rr_ptr     <= '0;
            byte_idx   <= '0;
            word       <= '0;
            frame_cnt  <= '0;
        end else begin
            settle_cnt <= settle_nxt;
            cur_ch     <= cur_nxt;
            rr_ptr     <= rr_nxt;
            byte_idx   <= idx_nxt;
            word       <= word_nxt;
            frame_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_out_tx_scheduler.sv
// Bench for out_tx_scheduler: directed scenarios plus random traffic, all cycles
// checked against a transaction-level model of grants, done pulses and byte streams.
module tb_out_tx_scheduler;

    localparam int         N_CH     = 4;
    localparam int         CH_BITS  = 2;
    localparam int         DATA_BIT = 32;
    localparam int         SETTLE   = 2;
    localparam logic [3:0] HDR_TAG  = 4'hA;
    localparam int         NB       = DATA_BIT / 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_CH-1:0]          ch_go;
    logic [N_CH*DATA_BIT-1:0] ch_data;
    logic [N_CH-1:0]          ch_done;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [CH_BITS-1:0]       cur_ch;
    logic                     busy;
    logic [15:0]              frame_cnt;

    always #5 clk = ~clk;

    out_tx_scheduler #(
        .N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_BIT(DATA_BIT), .SETTLE(SETTLE), .HDR_TAG(HDR_TAG)
    ) dut (
        .clk(clk), .reset(reset), .ch_go(ch_go), .ch_data(ch_data), .ch_done(ch_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cur_ch(cur_ch),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          m_free   = 1'b1;
    bit          m_stream = 1'b0;
    int          m_gch    = 0;
    int          m_gcyc   = 0;
    int          m_rr     = 0;
    logic [15:0] m_frames = '0;
    int          cyc      = 0;
    bit          load_req = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  acc_log[$];
    int          done_cnt[N_CH];

    function automatic int pick_ch(input logic [N_CH-1:0] go, input int rr);
        int c;
        for (int i = 0; i < N_CH; i++) begin
            c = (rr + i) % N_CH;
            if (go[c]) return c;
        end
        return 0;
    endfunction

    task automatic mon();
        logic [N_CH-1:0]     exp_done;
        logic [DATA_BIT-1:0] w;
        bit                  exp_valid;
        cyc++;
        if (reset === 1'b0) begin
            chk("rst_busy",  32'(busy),      32'd0);
            chk("rst_valid", 32'(tx_valid),  32'd0);
            chk("rst_data",  32'(tx_data),   32'd0);
            chk("rst_done",  32'(ch_done),   32'd0);
            chk("rst_cur",   32'(cur_ch),    32'd0);
            chk("rst_fcnt",  32'(frame_cnt), 32'd0);
            m_free = 1'b1; m_stream = 1'b0; exp_q.delete(); m_rr = 0; m_frames = '0;
            return;
        end
        if (load_req) begin
            m_frames = 16'hFFFF;
            load_req = 1'b0;
        end
        exp_done = '0;
        if (!m_free && !m_stream && cyc == m_gcyc + SETTLE + 1) exp_done[m_gch] = 1'b1;
        exp_valid = m_stream && (exp_q.size() > 0);
        chk("busy",  32'(busy),      32'(!m_free));
        chk("done",  32'(ch_done),   32'(exp_done));
        chk("valid", 32'(tx_valid),  32'(exp_valid));
        if (exp_valid) chk("data", 32'(tx_data), 32'(exp_q[0]));
        chk("fcnt",  32'(frame_cnt), 32'(m_frames));
        if (!m_free) chk("cur", 32'(cur_ch), 32'(m_gch));
        for (int k = 0; k < N_CH; k++) if (ch_done[k]) done_cnt[k]++;
        if (tx_valid && tx_ready) acc_log.push_back(tx_data);
        // advance the model to the next cycle
        if (m_free) begin
            if (ch_go != '0) begin
                m_gch = pick_ch(ch_go, m_rr); m_gcyc = cyc; m_free = 1'b0;
            end
        end else if (!m_stream) begin
            if (cyc <= m_gcyc + SETTLE) begin
                if (!ch_go[m_gch]) m_free = 1'b1;
            end else begin
                w = DATA_BIT'(ch_data >> (m_gch * DATA_BIT));
                exp_q.push_back({HDR_TAG, 1'b0, 3'(m_gch)});
                for (int b = 0; b < NB; b++) exp_q.push_back(8'(w >> (8 * (NB - 1 - b))));
                m_stream = 1'b1;
            end
        end else if (exp_q.size() > 0) begin
            if (tx_ready) void'(exp_q.pop_front());
        end else begin
            m_frames++; m_rr = (m_gch + 1) % N_CH; m_stream = 1'b0; m_free = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_log(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (acc_log.size() < target && n < budget) begin
            tick(); n++;
        end
        ok = (acc_log.size() >= target);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (ch_done == '0 && n < budget) begin
            tick(); n++;
        end
    endtask

    logic [7:0] sr_exp [5] = '{8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] rr_exp [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    logic [7:0] bp_exp [5] = '{8'hA1, 8'hCA, 8'hFE, 8'hF0, 8'h0D};

    initial begin
        int  n, base;
        int  d0[N_CH];
        bit  ok;
        reset = 1'b1; ch_go = '0; ch_data = '0; tx_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("idle_busy",  32'(busy),      32'd0);
        chk("idle_valid", 32'(tx_valid),  32'd0);
        chk("idle_fcnt",  32'(frame_cnt), 32'd0);

        // Single request on channel 2
        ch_data[2*DATA_BIT +: DATA_BIT] = 32'hDEADBEEF;
        tx_ready = 1'b1;
        base = acc_log.size();
        ch_go = 4'b0100;
        wait_done(20, n);
        chk("sr_done_lat", 32'(n), 32'(SETTLE + 1));
        chk("sr_done_vec", 32'(ch_done), 32'h4);
        ch_go = '0;
        tick();
        chk("sr_done_width", 32'(ch_done), 32'd0);
        wait_log(base + 5, 40, ok);
        chk("sr_wait", 32'(ok), 32'd1);
        if (ok) for (int i = 0; i < 5; i++) chk("sr_byte", 32'(acc_log[base+i]), 32'(sr_exp[i]));
        repeat (3) tick();
        chk("sr_fcnt", 32'(frame_cnt), 32'd1);
        chk("sr_busy", 32'(busy), 32'd0);

        // Round robin with all channels requesting
        do_reset();
        for (int k = 0; k < N_CH; k++) begin
            ch_data[k*DATA_BIT +: DATA_BIT] = 32'h11223344 + 32'(k) * 32'h01010101;
            d0[k] = done_cnt[k];
        end
        base = acc_log.size();
        ch_go = 4'hF;
        wait_log(base + 25, 80, ok);
        ch_go = '0;
        chk("rr_wait", 32'(ok), 32'd1);
        if (ok) for (int f = 0; f < 5; f++) chk("rr_hdr", 32'(acc_log[base+5*f]), 32'(rr_exp[f]));
        repeat (4) tick();
        for (int k = 0; k < N_CH; k++) chk("rr_done_cnt", 32'(done_cnt[k] - d0[k]), (k == 0) ? 32'd2 : 32'd1);

        // Backpressure during the second payload byte
        ch_data[1*DATA_BIT +: DATA_BIT] = 32'hCAFEF00D;
        base = acc_log.size();
        ch_go = 4'b0010;
        wait_done(20, n);
        chk("bp_done_seen", 32'(|ch_done), 32'd1);
        ch_go = '0;
        wait_log(base + 2, 20, ok);
        chk("bp_wait2", 32'(ok), 32'd1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_hold",  32'(tx_data),  32'hFE);
            tick();
        end
        tx_ready = 1'b1;
        wait_log(base + 5, 20, ok);
        chk("bp_wait5", 32'(ok), 32'd1);
        repeat (3) tick();
        chk("bp_count", 32'(acc_log.size() - base), 32'd5);
        if (ok) for (int i = 0; i < 5; i++) chk("bp_byte", 32'(acc_log[base+i]), 32'(bp_exp[i]));

        // Request withdrawn during SETTLE
        ch_go = 4'b0010;
        n = 0;
        while (!busy && n < 5) begin tick(); n++; end
        chk("gw_granted", 32'(busy), 32'd1);
        ch_go = '0;
        for (int i = 0; i < 6; i++) begin
            chk("gw_no_done",  32'(ch_done),  32'd0);
            chk("gw_no_valid", 32'(tx_valid), 32'd0);
            tick();
        end
        chk("gw_busy", 32'(busy), 32'd0);
        chk("gw_fcnt", 32'(frame_cnt), 32'd6);

        // Reset asserted mid-frame
        ch_data[2*DATA_BIT +: DATA_BIT] = 32'h01234567;
        base = acc_log.size();
        ch_go = 4'b0100;
        wait_log(base + 1, 20, ok);
        chk("rm_hdr_acc", 32'(ok), 32'd1);
        ch_go = 4'b1101;
        #2 reset = 1'b0;
        #1;
        chk("rm_async_valid", 32'(tx_valid),  32'd0);
        chk("rm_async_busy",  32'(busy),      32'd0);
        chk("rm_async_data",  32'(tx_data),   32'd0);
        chk("rm_async_done",  32'(ch_done),   32'd0);
        chk("rm_async_cur",   32'(cur_ch),    32'd0);
        chk("rm_async_fcnt",  32'(frame_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        base = acc_log.size();
        wait_done(20, n);
        chk("rm_done_vec", 32'(ch_done), 32'h1);
        ch_go = '0;
        wait_log(base + 5, 20, ok);
        chk("rm_wait", 32'(ok), 32'd1);
        if (ok) chk("rm_first_hdr", 32'(acc_log[base]), 32'hA0);

        // Frame counter wrap
        repeat (3) tick();
        force dut.frame_cnt = 16'hFFFF;
        load_req = 1'b1;
        repeat (3) tick();
        release dut.frame_cnt;
        tick();
        chk("wrap_pre", 32'(frame_cnt), 32'hFFFF);
        base = acc_log.size();
        ch_go = 4'b1000;
        wait_done(20, n);
        ch_go = '0;
        wait_log(base + 5, 20, ok);
        chk("wrap_wait", 32'(ok), 32'd1);
        repeat (3) tick();
        chk("wrap_zero", 32'(frame_cnt), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) ch_go = 4'($urandom);
            if ($urandom_range(3) == 0) ch_data[$urandom_range(N_CH-1)*DATA_BIT +: DATA_BIT] = $urandom;
            tx_ready = ($urandom_range(3) != 0);
            tick();
        end
        ch_go = '0;
        tx_ready = 1'b1;
        repeat (30) tick();
        chk("rand_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/out_tx_scheduler.md
Name: out_tx_scheduler

Overview:
- Round-robin scheduler that shares one byte-wide transmit link among N_CH output FIFO buffers. Each buffer presents one packed DATA_BIT-bit word and a go flag.
- Grants one channel at a time, waits for the word to settle, then latches it. Issues a one-cycle done pulse back to that buffer so it releases the slot.
- Streams the latched word as a header byte followed by DATA_BIT/8 payload bytes, MSB first, over a valid/ready handshake to the serializer.
- Sits between the per-channel filter/packer chains and the UART/SPI serializer.

Parameters:
- N_CH, 4, number of requesting channel buffers (2..8).
- CH_BITS, 2, width of the channel index; must equal clog2(N_CH).
- DATA_BIT, 32, packed word width; must be a multiple of 8.
- SETTLE, 2, cycles between grant and latch, allowing the buffer's word register to update (1..15).
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ch_go  in  N_CH  per-channel word-available flag (level).
- ch_data  in  N_CH*DATA_BIT  packed words; channel k occupies bits [k*DATA_BIT +: DATA_BIT].
- ch_done  out  N_CH  one-hot, one-cycle release pulse to the granted channel.
- tx_data  out  8  byte to the serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte.
- cur_ch  out  CH_BITS  currently or last granted channel.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  16  count of completed frames; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE; ch_done = 0; tx_valid = 0; tx_data = 0; cur_ch = 0; busy = 0; frame_cnt = 0; rr_ptr = 0; word register = 0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse and no further bytes are issued.
- States: IDLE, SETTLE, LATCH, HDR, PAY, DONE.
- IDLE:
  - If any ch_go is high, grant the first channel at or after rr_ptr, searching upward and wrapping modulo N_CH.
  - Set cur_ch to that channel and go to SETTLE with settle_cnt = 0.
  - If no ch_go is high, stay in IDLE.
- SETTLE:
  - Increment settle_cnt each cycle. When settle_cnt = SETTLE-1, go to LATCH.
  - If ch_go[cur_ch] drops during SETTLE, return to IDLE. No done pulse; rr_ptr is unchanged.
- LATCH (one cycle):
  - Capture ch_data for cur_ch into the word register.
  - Drive ch_done[cur_ch] = 1 for exactly this cycle; all other ch_done bits stay 0.
  - Go to HDR.
- HDR:
  - tx_valid = 1; tx_data = {HDR_TAG, 1'b0, cur_ch zero-extended to 3 bits}.
  - Hold tx_data and tx_valid until the cycle where tx_ready = 1, then go to PAY with byte_idx = 0.
- PAY:
  - tx_data = word[DATA_BIT-1-8*byte_idx -: 8], with tx_valid = 1.
  - On tx_ready, increment byte_idx. When the last byte (byte_idx = DATA_BIT/8-1) is accepted, go to DONE.
  - tx_valid never drops while a byte is pending.
  - tx_data is stable while tx_valid = 1 and tx_ready = 0.
- DONE (one cycle):
  - tx_valid = 0; frame_cnt increments; rr_ptr = cur_ch+1 modulo N_CH.
  - Go to IDLE.
- Latency:
  - Grant to done pulse: SETTLE+1 cycles.
  - Grant to first tx_valid: SETTLE+2 cycles.
  - Minimum frame with tx_ready tied high: SETTLE + 1 + 1 + DATA_BIT/8 + 1 cycles, i.e. 9 cycles at the defaults.
- Fairness: a channel that has just been served has the lowest priority in the next arbitration. All N_CH channels continuously requesting are served in strict rotation.
- Requests arriving while busy are not lost, because ch_go is a level. A ch_go that pulses and falls entirely within a busy period is not serviced.
- tx_ready while tx_valid = 0 is ignored.

Test Plan:
- Single request:
  - Stimulus: reset, then ch_go = 4'b0100, ch_data[2] = 32'hDEADBEEF, tx_ready held high.
  - Required: ch_done = 4'b0100 for 1 cycle, 3 cycles after grant. Bytes A2, DE, AD, BE, EF on consecutive cycles. frame_cnt = 1; busy returns low.
- Round robin:
  - Stimulus: ch_go = 4'b1111 held, distinct data per channel.
  - Required: header sequence A0, A1, A2, A3, A0; each channel gets exactly one done pulse per rotation.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles during the second payload byte.
  - Required: tx_data and tx_valid stay constant across the stall; no byte is duplicated or skipped; the frame still emits 5 bytes.
- Go withdrawn:
  - Stimulus: ch_go[1] falls during SETTLE.
  - Required: return to IDLE; ch_done stays 0; no tx_valid; frame_cnt unchanged.
- Reset mid-frame:
  - Stimulus: assert reset after the header byte is accepted.
  - Required: tx_valid = 0 asynchronously; all outputs at reset values. After release, a fresh request starts from channel 0.
- Counter wrap:
  - Stimulus: force frame_cnt to 16'hFFFF, then complete one frame.
  - Required: frame_cnt = 0.
